// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
//   Parametrised UART transmitter. Sends a start bit, DATA_BITS data bits
//   (LSB first), an optional odd/even parity bit and 1 or 2 stop bits. Each
//   bit lasts BAUD_DIV clk cycles. A ready/valid handshake accepts a word
//   only while idle, so the block can be fed straight from a FIFO.
//
// Parameters
//   BAUD_DIV   clk cycles per bit (>= 2)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   tx_data   in   word to send, sampled on the accept edge only
//   tx_valid  in   word available (may be held for back-to-back frames)
//   tx_ready  out  high while idle; accept = tx_valid & tx_ready
//   dout      out  registered serial line, idles high
//   busy      out  high from the accept edge to the end of the last stop bit
//   done      out  one-cycle pulse in the first idle cycle after a frame
//
// States
//   S_IDLE   | line high, waiting for tx_valid
//   S_START  | start bit (low)
//   S_DATA   | data bits, LSB first, bit_cnt tracks position
//   S_PARITY | parity bit (skipped when PARITY == 0)
//   S_STOP   | stop bit(s), bit_cnt reused as stop-bit index
// -----------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int BAUD_DIV  = 10416,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 dout,
  output logic                 busy,
  output logic                 done
);

  // Elaboration-time guards against unsupported configurations
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_cfg: BAUD_DIV must be >= 2");
  end

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 tick;

  assign tick     = (baud_cnt == BAUD_LAST);
  assign tx_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      dout     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      // Baud counter free-runs only inside a frame and wraps on the tick
      if (state == S_IDLE || tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end

      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          dout    <= 1'b1;
          if (tx_valid) begin
            shreg   <= tx_data;
            // Parity is fixed at accept so the PARITY state only replays it
            par_bit <= (PARITY == 1) ? ~^tx_data : ^tx_data;
            state   <= S_START;
            dout    <= 1'b0;
            busy    <= 1'b1;
          end
        end

        S_START: begin
          if (tick) begin
            state   <= S_DATA;
            dout    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
        end

        S_DATA: begin
          if (tick) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= S_PARITY;
                dout  <= par_bit;
              end else begin
                state <= S_STOP;
                dout  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              dout    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end

        S_PARITY: begin
          if (tick) begin
            state   <= S_STOP;
            dout    <= 1'b1;
            bit_cnt <= '0;
          end
        end

        S_STOP: begin
          dout <= 1'b1;
          if (tick) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          dout  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
//   Five instances of uart_tx_cfg in different configurations. Stimulus pushes
//   the expected frame into a scoreboard queue; one monitor per instance
//   captures dout while busy and, on the done pulse, decodes the frame and
//   compares it against the popped entry.
//   Instances: 0 = 8N1 div4, 1 = 8E1 div4, 2 = 8O1 div4, 3 = 8N2 div4,
//              4 = 7O1 div3.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

  logic clk;
  logic [4:0] rst_v;
  logic [4:0] tv;
  logic [8:0] td [5];
  logic [4:0] dout_v, busy_v, done_v, ready_v;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int id;
    int data;
    int par;   // expected parity bit, -1 when the frame has none
    int len;   // expected busy length in clk cycles
    int gap;   // expected idle cycles before this frame, -1 = don't care
  } exp_t;

  exp_t sb[$];

  int cfg_baud  [5] = '{4, 4, 4, 4, 3};
  int cfg_nbits [5] = '{8, 8, 8, 8, 7};
  int cfg_par   [5] = '{0, 1, 1, 0, 1};
  int cfg_stop  [5] = '{1, 1, 1, 2, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_cfg #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst_v[0]), .tx_data(td[0][7:0]), .tx_valid(tv[0]),
    .tx_ready(ready_v[0]), .dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx_cfg #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .tx_data(td[1][7:0]), .tx_valid(tv[1]),
    .tx_ready(ready_v[1]), .dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx_cfg #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst_v[2]), .tx_data(td[2][7:0]), .tx_valid(tv[2]),
    .tx_ready(ready_v[2]), .dout(dout_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx_cfg #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst_v[3]), .tx_data(td[3][7:0]), .tx_valid(tv[3]),
    .tx_ready(ready_v[3]), .dout(dout_v[3]), .busy(busy_v[3]), .done(done_v[3]));
  uart_tx_cfg #(.BAUD_DIV(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u4 (
    .clk(clk), .rst(rst_v[4]), .tx_data(td[4][6:0]), .tx_valid(tv[4]),
    .tx_ready(ready_v[4]), .dout(dout_v[4]), .busy(busy_v[4]), .done(done_v[4]));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input int data, input int par,
                          input int len, input int gap);
    exp_t e;
    e.id = id; e.data = data; e.par = par; e.len = len; e.gap = gap;
    sb.push_back(e);
  endtask

  // Monitor: records dout every cycle busy is high, checks on the done pulse
  task automatic mon(input int k);
    logic [255:0] s;
    int n = 0;
    int ready_bad = 0;
    int idle_cnt = 1000;
    int gap_at_start = -1;
    s = '0;
    forever begin
      @(negedge clk);
      if (rst_v[k]) begin
        n = 0; ready_bad = 0; idle_cnt = 1000; s = '0;
      end else begin
        if (busy_v[k]) begin
          if (n == 0) gap_at_start = idle_cnt;
          if (n < 256) s[n] = dout_v[k];
          n++;
          if (ready_v[k]) ready_bad++;
          idle_cnt = 0;
        end else begin
          idle_cnt++;
          if (!ready_v[k]) ready_bad++;
        end
        if (done_v[k]) begin
          chk($sformatf("done_follows_frame[%0d]", k), int'(n > 0), 1);
          if (n > 0) begin
            chk($sformatf("frame_expected[%0d]", k), int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
              exp_t e;
              int b, nb, hp, ns, nbits_total, unstable, w, stop_bad;
              e = sb.pop_front();
              b  = cfg_baud[k];
              nb = cfg_nbits[k];
              hp = cfg_par[k];
              ns = cfg_stop[k];
              nbits_total = 1 + nb + hp + ns;
              unstable = 0; w = 0; stop_bad = 0;
              for (int i = 0; i < nbits_total; i++)
                for (int j = 1; j < b; j++)
                  if (s[i*b+j] !== s[i*b]) unstable++;
              for (int i = 0; i < nb; i++)
                w = w | (int'(s[(1+i)*b]) << i);
              for (int i = 0; i < ns; i++)
                if (s[(1+nb+hp+i)*b] !== 1'b1) stop_bad++;
              chk($sformatf("frame_id[%0d]", k), k, e.id);
              chk($sformatf("frame_len[%0d]", k), n, e.len);
              chk($sformatf("bit_stable[%0d]", k), unstable, 0);
              chk($sformatf("start_bit[%0d]", k), int'(s[0]), 0);
              chk($sformatf("data[%0d]", k), w, e.data);
              if (e.par >= 0)
                chk($sformatf("parity_bit[%0d]", k), int'(s[(1+nb)*b]), e.par);
              chk($sformatf("stop_bits[%0d]", k), stop_bad, 0);
              chk($sformatf("ready_vs_busy[%0d]", k), ready_bad, 0);
              if (e.gap >= 0)
                chk($sformatf("idle_gap[%0d]", k), gap_at_start, e.gap);
            end
          end
          n = 0; ready_bad = 0; s = '0;
        end
      end
    end
  endtask

  // Drive a word and return #1 after the accept edge
  task automatic send(input int k, input int data, input bit hold);
    int cyc = 0;
    td[k] = data[8:0];
    tv[k] = 1'b1;
    while (!ready_v[k] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("accept_bounded[%0d]", k), int'(cyc < 200), 1);
    @(posedge clk); #1;
    if (!hold) tv[k] = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() != 0 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    chk("drain_bounded", int'(c < 2000), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      mon(0); mon(1); mon(2); mon(3); mon(4);
    join_none
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tv = '0;
    for (int k = 0; k < 5; k++) td[k] = '0;
    rst_v = '1;
    #12;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rst_dout[%0d]", k), int'(dout_v[k]), 1);
      chk($sformatf("rst_busy[%0d]", k), int'(busy_v[k]), 0);
      chk($sformatf("rst_done[%0d]", k), int'(done_v[k]), 0);
      chk($sformatf("rst_ready[%0d]", k), int'(ready_v[k]), 1);
    end
    @(posedge clk); #1;
    rst_v = '0;
    repeat (2) @(posedge clk); #1;

    // 8N1 0xA5: 40-cycle frame
    push_exp(0, 'hA5, -1, 40, -1);
    send(0, 'hA5, 1'b0);
    drain();

    // 0x07 with even parity (bit = 1) and odd parity (bit = 0)
    push_exp(1, 'h07, 1, 44, -1);
    send(1, 'h07, 1'b0);
    drain();
    push_exp(2, 'h07, 0, 44, -1);
    send(2, 'h07, 1'b0);
    drain();

    // Two stop bits, back-to-back with tx_valid held: one idle cycle between
    push_exp(3, 'h55, -1, 44, -1);
    push_exp(3, 'h0F, -1, 44, 1);
    send(3, 'h55, 1'b1);
    td[3] = 9'h00F;
    send(3, 'h0F, 1'b0);
    drain();

    // New word offered mid-frame is ignored and dropped before idle
    push_exp(0, 'h3C, -1, 40, -1);
    send(0, 'h3C, 1'b0);
    repeat (9) @(posedge clk); #1;
    tv[0] = 1'b1;
    td[0] = 9'h0FF;
    repeat (10) @(posedge clk); #1;
    tv[0] = 1'b0;
    drain();

    // Async reset in the middle of data bit 3 (cycles 16..19 of the frame)
    send(0, 'h5A, 1'b0);
    repeat (17) @(posedge clk);
    #2;
    chk("busy_before_rst", int'(busy_v[0]), 1);
    rst_v[0] = 1'b1;
    #1;
    chk("async_rst_dout", int'(dout_v[0]), 1);
    chk("async_rst_busy", int'(busy_v[0]), 0);
    chk("async_rst_ready", int'(ready_v[0]), 1);
    repeat (2) @(posedge clk); #1;
    rst_v[0] = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", int'(ready_v[0]), 1);
    push_exp(0, 'h81, -1, 40, -1);
    send(0, 'h81, 1'b0);
    drain();

    // 7 data bits, odd parity, divider 3: 0x7F -> parity 0, 30 cycles
    push_exp(4, 'h7F, 0, 30, -1);
    send(4, 'h7F, 1'b0);
    drain();

    repeat (10) @(posedge clk); #1;
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
